// File: rtl/gb_joypad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gb_joypad_ctrl_pkg
// Purpose  : Shared types and constants for the DMG joypad controller.
// Revision : 1.0 - initial release
// ============================================================================
package gb_joypad_ctrl_pkg;

    // Active-low button set; bits 7:4 form the direction nibble, 3:0 the action nibble.
    typedef struct packed {
        logic down;
        logic up;
        logic left;
        logic right;
        logic start;
        logic select;
        logic b;
        logic a;
    } cntrlr_data;

    localparam int         P1_SEL_DIR_BIT = 4;
    localparam int         P1_SEL_ACT_BIT = 5;
    localparam int         IF_JOYPAD_BIT  = 4;
    localparam logic [7:0] P1_RESET_VAL   = 8'hCF;

    // A set select bit deselects its group, forcing that group's nibble to all-released.
    function automatic logic [3:0] p1_nibble(input cntrlr_data d, input logic [1:0] sel);
        logic [3:0] dir;
        logic [3:0] act;
        dir = {d.down, d.up, d.left, d.right};
        act = {d.start, d.select, d.b, d.a};
        p1_nibble = (sel[0] ? 4'hF : dir) & (sel[1] ? 4'hF : act);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gb_joypad_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gb_joypad_ctrl_if
// Purpose  : P1 register MMIO bus and joypad interrupt request.
// Revision : 1.0 - initial release
// ============================================================================
interface gb_joypad_ctrl_if;

    logic       p1_wr;
    logic [7:0] p1_wdata;
    logic [7:0] p1_rdata;
    logic       irq_joypad;

    modport master (
        output p1_wr,
        output p1_wdata,
        input  p1_rdata,
        input  irq_joypad
    );

    modport slave (
        input  p1_wr,
        input  p1_wdata,
        output p1_rdata,
        output irq_joypad
    );

endinterface
`default_nettype wire

// File: rtl/gb_joypad_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gb_debounce
// Purpose  : Two-flop synchroniser plus stability counter for one button bit.
// Revision : 1.0 - initial release
// ============================================================================
module gb_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_state
);

    localparam int                 c_cnt_w   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_state;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample that agrees with the current state restarts qualification.
            if (r_sync2 == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_state <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/gb_joypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gb_joypad_ctrl
// Purpose  : DMG joypad P1 register with debounce, pad select and joypad irq.
//            Optional GB_JOYPAD_SOCD_EN releases opposing direction pairs.
// Revision : 1.0 - initial release
// ============================================================================
module gb_joypad_ctrl
    import gb_joypad_ctrl_pkg::*;
#(
    parameter  int N_PADS    = 1,
    parameter  int DB_CYCLES = 16,
    localparam int SEL_W     = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  cntrlr_data       btn_raw [N_PADS],
    input  logic [SEL_W-1:0] pad_sel,
    gb_joypad_ctrl_if.slave  bus
);

    logic [8*N_PADS-1:0] w_deb_flat;
    cntrlr_data          w_pad;
    cntrlr_data          w_clean;
    logic [3:0]          w_nib;
    logic [1:0]          r_sel;
    logic [3:0]          r_prev;
    logic                r_irq;

    for (genvar p = 0; p < N_PADS; p++) begin : g_pad
        for (genvar b = 0; b < 8; b++) begin : g_bit
            gb_debounce #(
                .DB_CYCLES (DB_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset   (reset),
                .i_raw   (btn_raw[p][b]),
                .o_state (w_deb_flat[8*p + b])
            );
        end
    end

    // Out-of-range pad_sel values fall through to pad 0.
    always_comb begin
        w_pad = cntrlr_data'(w_deb_flat[7:0]);
        for (int i = 1; i < N_PADS; i++) begin
            if (pad_sel == SEL_W'(i)) begin
                w_pad = cntrlr_data'(w_deb_flat[8*i +: 8]);
            end
        end
    end

    always_comb begin
        w_clean = w_pad;
`ifdef GB_JOYPAD_SOCD_EN
        if (!w_pad.up && !w_pad.down) begin
            w_clean.up   = 1'b1;
            w_clean.down = 1'b1;
        end
        if (!w_pad.left && !w_pad.right) begin
            w_clean.left  = 1'b1;
            w_clean.right = 1'b1;
        end
`endif
    end

    assign w_nib = p1_nibble(w_clean, r_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel  <= 2'b00;
            r_prev <= 4'hF;
            r_irq  <= 1'b0;
        end else begin
            if (bus.p1_wr) begin
                r_sel <= {bus.p1_wdata[P1_SEL_ACT_BIT], bus.p1_wdata[P1_SEL_DIR_BIT]};
            end
            // Edge detect on the visible nibble, so select and pad changes fire too.
            r_prev <= w_nib;
            r_irq  <= |(r_prev & ~w_nib);
        end
    end

    assign bus.p1_rdata   = {P1_RESET_VAL[7:6], r_sel, w_nib};
    assign bus.irq_joypad = r_irq;

endmodule
`default_nettype wire
